// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the fetch/data memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS_D = 2'd1,
    ST_BUS_I = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  // Reused from the core's common defines
  localparam logic ChipEnable  = 1'b1;
  localparam logic WriteEnable = 1'b1;

  localparam logic [3:0]  SelAll      = 4'hF;
  localparam int unsigned StallIfBit  = 1;
  localparam int unsigned StallMemBit = 4;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one req/ack memory bus between the fetch and data ports, raising
// per-port stall requests and draining bus cycles orphaned by a flush.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_stallreq_o,
  input  logic              d_ce_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_sel_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_stallreq_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i
);

  arb_state_e        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              d_done_q, d_done_d;
  logic              i_done_q, i_done_d;
  logic [DATA_W-1:0] d_hold_q, d_hold_d;
  logic [DATA_W-1:0] i_hold_q, i_hold_d;
  logic              d_set_c, i_set_c;
  logic              d_ack_c, i_ack_c, drain_c;
  logic              unused_stall_c;

  assign unused_stall_c = ^{stall_i[5], stall_i[3:2], stall_i[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      d_done_q    <= 1'b0;
      i_done_q    <= 1'b0;
      d_hold_q    <= '0;
      i_hold_q    <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      d_done_q    <= d_done_d;
      i_done_q    <= i_done_d;
      d_hold_q    <= d_hold_d;
      i_hold_q    <= i_hold_d;
    end
  end

  // Next state, bus latching and completion bookkeeping
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    d_hold_d    = d_hold_q;
    i_hold_d    = i_hold_q;
    d_set_c     = 1'b0;
    i_set_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (d_ce_i == ChipEnable && !d_done_q) begin
          state_d     = ST_BUS_D;
          bus_req_d   = 1'b1;
          bus_we_d    = d_we_i;
          bus_sel_d   = d_sel_i;
          bus_addr_d  = d_addr_i;
          bus_wdata_d = d_wdata_i;
        end else if (if_ce_i == ChipEnable && !i_done_q) begin
          state_d     = ST_BUS_I;
          bus_req_d   = 1'b1;
          bus_we_d    = ~WriteEnable;
          bus_sel_d   = SelAll;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
        end
      end
      ST_BUS_D: begin
        if (bus_ack_i) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          if (!flush_i) begin
            d_set_c  = 1'b1;
            d_hold_d = bus_rdata_i;
          end
        end else if (flush_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_BUS_I: begin
        if (bus_ack_i) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          if (!flush_i) begin
            i_set_c  = 1'b1;
            i_hold_d = bus_rdata_i;
          end
        end else if (flush_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Orphaned cycle: wait out the slave, then drop its data
        if (bus_ack_i) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase

    // A clear at the same edge as a set wins
    d_done_d = (d_done_q | d_set_c) & stall_i[StallMemBit] & ~flush_i;
    i_done_d = (i_done_q | i_set_c) & stall_i[StallIfBit] & ~flush_i;
  end

  assign d_ack_c = (state_q == ST_BUS_D) & bus_ack_i;
  assign i_ack_c = (state_q == ST_BUS_I) & bus_ack_i;
  assign drain_c = (state_q == ST_DRAIN);

  // Port-side results are combinational so a completing ack releases the stall in its own cycle
  assign d_stallreq_o  = ~rst & d_ce_i  & (drain_c | (~d_done_q & ~d_ack_c));
  assign if_stallreq_o = ~rst & if_ce_i & (drain_c | (~i_done_q & ~i_ack_c));
  assign d_rdata_o     = rst ? '0 : (d_done_q ? d_hold_q : bus_rdata_i);
  assign if_data_o     = rst ? '0 : (i_done_q ? i_hold_q : bus_rdata_i);

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall_i;
  logic          flush_i;
  logic          if_ce_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_data_o;
  logic          if_stallreq_o;
  logic          d_ce_i;
  logic          d_we_i;
  logic [3:0]    d_sel_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [DW-1:0] d_rdata_o;
  logic          d_stallreq_o;
  logic          bus_req_o;
  logic          bus_we_o;
  logic [3:0]    bus_sel_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic [DW-1:0] bus_rdata_i;
  logic          bus_ack_i;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .if_stallreq_o(if_stallreq_o), .d_ce_i(d_ce_i), .d_we_i(d_we_i),
    .d_sel_i(d_sel_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_stallreq_o(d_stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic dce, input logic dwe, input logic ice, input logic ack,
                        input logic [5:0] stl, input logic fl, input logic [31:0] rd);
    d_ce_i = dce; d_we_i = dwe; if_ce_i = ice; bus_ack_i = ack;
    stall_i = stl; flush_i = fl; bus_rdata_i = rd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 32'h0);
    d_sel_i = 4'h0; d_addr_i = '0; d_wdata_i = '0; if_addr_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        d_ce;
    logic        if_ce;
    logic        ack;
    logic [5:0]  stall;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_dst;
    logic        e_ist;
    logic [31:0] e_drd;
    logic [31:0] e_ird;
  } vec_t;

  function automatic vec_t mk(input logic dce, input logic ice, input logic ack,
                              input logic [5:0] stl, input logic [31:0] rd,
                              input logic req, input logic [31:0] addr, input logic dst,
                              input logic ist, input logic [31:0] drd, input logic [31:0] ird);
    vec_t v;
    v.d_ce = dce; v.if_ce = ice; v.ack = ack; v.stall = stl; v.rdata = rd;
    v.e_req = req; v.e_addr = addr; v.e_dst = dst; v.e_ist = ist;
    v.e_drd = drd; v.e_ird = ird;
    return v;
  endfunction

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    bit          is_d;
    bit          drop;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        bus_q[$];
  bit          m_d_done, m_i_done;
  logic [31:0] m_d_hold, m_i_hold;

  task automatic model_reset();
    bus_q.delete();
    m_d_done = 1'b0; m_i_done = 1'b0;
    m_d_hold = '0;   m_i_hold = '0;
  endtask

  task automatic model_check();
    bit   busy, drain, d_hit, i_hit;
    txn_t f;
    busy  = (bus_q.size() != 0);
    drain = 1'b0; d_hit = 1'b0; i_hit = 1'b0;
    if (busy) begin
      f     = bus_q[0];
      drain = f.drop;
      d_hit = !f.drop && f.is_d && (bus_ack_i == 1'b1);
      i_hit = !f.drop && !f.is_d && (bus_ack_i == 1'b1);
    end
    chk1("rnd_req", bus_req_o, busy);
    if (busy) begin
      chk32("rnd_addr", bus_addr_o, f.addr);
      chk1("rnd_we", bus_we_o, f.we);
      chk32("rnd_sel", 32'(bus_sel_o), 32'(f.sel));
      if (f.is_d) chk32("rnd_wdata", bus_wdata_o, f.wdata);
    end
    chk1("rnd_dstall", d_stallreq_o, d_ce_i & (drain | (!m_d_done & !d_hit)));
    chk1("rnd_istall", if_stallreq_o, if_ce_i & (drain | (!m_i_done & !i_hit)));
    chk32("rnd_drdata", d_rdata_o, m_d_done ? m_d_hold : bus_rdata_i);
    chk32("rnd_idata", if_data_o, m_i_done ? m_i_hold : bus_rdata_i);
  endtask

  task automatic model_step();
    bit   set_d, set_i;
    txn_t t;
    set_d = 1'b0; set_i = 1'b0;
    if (bus_q.size() == 0) begin
      if (d_ce_i && !m_d_done) begin
        t.is_d = 1'b1; t.drop = 1'b0; t.we = d_we_i; t.sel = d_sel_i;
        t.addr = d_addr_i; t.wdata = d_wdata_i;
        bus_q.push_back(t);
      end else if (if_ce_i && !m_i_done) begin
        t.is_d = 1'b0; t.drop = 1'b0; t.we = 1'b0; t.sel = 4'hF;
        t.addr = if_addr_i; t.wdata = '0;
        bus_q.push_back(t);
      end
    end else if (bus_ack_i) begin
      t = bus_q.pop_front();
      if (!t.drop && !flush_i) begin
        if (t.is_d) begin set_d = 1'b1; m_d_hold = bus_rdata_i; end
        else        begin set_i = 1'b1; m_i_hold = bus_rdata_i; end
      end
    end else if (flush_i) begin
      t = bus_q[0];
      t.drop = 1'b1;
      bus_q[0] = t;
    end
    m_d_done = (m_d_done | set_d) & stall_i[4] & !flush_i;
    m_i_done = (m_i_done | set_i) & stall_i[1] & !flush_i;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    int   writes;
    int   deliveries;
    logic prev_req;
    bit   seen;

    // ---------------- reset state ----------------
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 32'h0);
    d_sel_i = 4'h0; d_addr_i = '0; d_wdata_i = '0; if_addr_i = '0;
    @(negedge clk);
    chk1("rst_req", bus_req_o, 1'b0);
    chk1("rst_we", bus_we_o, 1'b0);
    chk32("rst_sel", 32'(bus_sel_o), 32'h0);
    chk32("rst_addr", bus_addr_o, 32'h0);
    chk32("rst_wdata", bus_wdata_o, 32'h0);
    chk1("rst_dstall", d_stallreq_o, 1'b0);
    chk1("rst_istall", if_stallreq_o, 1'b0);
    chk32("rst_drdata", d_rdata_o, 32'h0);
    chk32("rst_idata", if_data_o, 32'h0);

    // ---------------- table: simultaneous load 0x100 and fetch 0x200 ----------------
    vecs[0] = mk(1'b1, 1'b1, 1'b0, 6'h1F, 32'h0,        1'b0, 32'h0,   1'b1, 1'b1, 32'h0,        32'h0);
    vecs[1] = mk(1'b1, 1'b1, 1'b1, 6'h1F, 32'hAAAA0001, 1'b1, 32'h100, 1'b0, 1'b1, 32'hAAAA0001, 32'hAAAA0001);
    vecs[2] = mk(1'b1, 1'b1, 1'b0, 6'h1F, 32'h55555555, 1'b0, 32'h0,   1'b0, 1'b1, 32'hAAAA0001, 32'h55555555);
    vecs[3] = mk(1'b1, 1'b1, 1'b0, 6'h1F, 32'h0,        1'b1, 32'h200, 1'b0, 1'b1, 32'hAAAA0001, 32'h0);
    vecs[4] = mk(1'b1, 1'b1, 1'b1, 6'h1F, 32'h3C020002, 1'b1, 32'h200, 1'b0, 1'b0, 32'hAAAA0001, 32'h3C020002);
    vecs[5] = mk(1'b1, 1'b1, 1'b0, 6'h00, 32'h12345678, 1'b0, 32'h0,   1'b0, 1'b0, 32'hAAAA0001, 32'h3C020002);
    vecs[6] = mk(1'b0, 1'b0, 1'b0, 6'h00, 32'h0BADF00D, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0BADF00D, 32'h0BADF00D);
    vecs[7] = mk(1'b0, 1'b0, 1'b1, 6'h00, 32'h00000001, 1'b0, 32'h0,   1'b0, 1'b0, 32'h00000001, 32'h00000001);
    vecs[8] = mk(1'b0, 1'b0, 1'b0, 6'h00, 32'h00000002, 1'b0, 32'h0,   1'b0, 1'b0, 32'h00000002, 32'h00000002);

    do_reset();
    d_addr_i = 32'h100; if_addr_i = 32'h200; d_sel_i = 4'hF;
    for (int i = 0; i < 9; i++) begin
      set_in(vecs[i].d_ce, 1'b0, vecs[i].if_ce, vecs[i].ack, vecs[i].stall, 1'b0, vecs[i].rdata);
      @(negedge clk);
      chk1($sformatf("tbl%0d_req", i), bus_req_o, vecs[i].e_req);
      if (vecs[i].e_req) chk32($sformatf("tbl%0d_addr", i), bus_addr_o, vecs[i].e_addr);
      chk1($sformatf("tbl%0d_dstall", i), d_stallreq_o, vecs[i].e_dst);
      chk1($sformatf("tbl%0d_istall", i), if_stallreq_o, vecs[i].e_ist);
      chk32($sformatf("tbl%0d_drdata", i), d_rdata_o, vecs[i].e_drd);
      chk32($sformatf("tbl%0d_idata", i), if_data_o, vecs[i].e_ird);
      if (i == 3) begin
        chk1("tbl3_fetch_we", bus_we_o, 1'b0);
        chk32("tbl3_fetch_sel", 32'(bus_sel_o), 32'hF);
      end
      nxt();
    end

    // ---------------- fetch with slow slave ----------------
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b0, 1'b1, (k == 3), 6'h00, 1'b0, (k == 3) ? 32'h3C010001 : 32'h0);
      @(negedge clk);
      chk1($sformatf("slow%0d_req", k), bus_req_o, (k != 0));
      chk1($sformatf("slow%0d_istall", k), if_stallreq_o, (k != 3));
      if (k == 3) chk32("slow_idata", if_data_o, 32'h3C010001);
      nxt();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 32'h0);
    @(negedge clk);
    chk1("slow_req_after_ack", bus_req_o, 1'b0);
    nxt();

    // ---------------- store held by MEM stall: single bus write ----------------
    do_reset();
    d_addr_i = 32'h40; d_sel_i = 4'b0011; d_wdata_i = 32'hDEADBEEF;
    writes = 0; prev_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      set_in((k <= 7), 1'b1, 1'b0, (k == 1), (k <= 6) ? 6'h1F : 6'h00, 1'b0, 32'h0);
      @(negedge clk);
      if (bus_req_o && !prev_req && bus_we_o) writes++;
      prev_req = bus_req_o;
      if (k == 1) begin
        chk1("st_we", bus_we_o, 1'b1);
        chk32("st_sel", 32'(bus_sel_o), 32'h3);
        chk32("st_addr", bus_addr_o, 32'h40);
        chk32("st_wdata", bus_wdata_o, 32'hDEADBEEF);
      end
      if (k >= 1 && k <= 7) chk1($sformatf("st%0d_dstall", k), d_stallreq_o, 1'b0);
      nxt();
    end
    chk32("st_write_count", 32'(writes), 32'd1);

    // ---------------- flush mid-fetch drains, then new pc ----------------
    do_reset();
    if_addr_i = 32'h300;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 32'h0);
    @(negedge clk); chk1("fl0_req", bus_req_o, 1'b0); nxt();
    @(negedge clk); chk1("fl1_req", bus_req_o, 1'b1); chk32("fl1_addr", bus_addr_o, 32'h300); nxt();
    flush_i = 1'b1;
    @(negedge clk); chk1("fl2_istall", if_stallreq_o, 1'b1); nxt();
    flush_i = 1'b0; if_addr_i = 32'h20;
    @(negedge clk); chk1("fl3_req", bus_req_o, 1'b1); chk32("fl3_addr", bus_addr_o, 32'h300);
    chk1("fl3_istall", if_stallreq_o, 1'b1); nxt();
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
    @(negedge clk); chk1("fl4_req", bus_req_o, 1'b1); chk1("fl4_istall_forced", if_stallreq_o, 1'b1); nxt();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h00000077;
    @(negedge clk); chk1("fl5_req", bus_req_o, 1'b0); chk1("fl5_istall", if_stallreq_o, 1'b1);
    chk32("fl5_idata_discarded", if_data_o, 32'h00000077); nxt();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h11112222;
    @(negedge clk); chk1("fl6_req", bus_req_o, 1'b1); chk32("fl6_addr", bus_addr_o, 32'h20);
    chk1("fl6_istall", if_stallreq_o, 1'b0); chk32("fl6_idata", if_data_o, 32'h11112222); nxt();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 32'h0);
    @(negedge clk); chk1("fl7_req", bus_req_o, 1'b0); nxt();

    // ---------------- zero-wait slave: one fetch every 2 cycles ----------------
    do_reset();
    deliveries = 0;
    for (int k = 0; k < 10; k++) begin
      set_in(1'b0, 1'b0, 1'b1, (k % 2 == 1), 6'h00, 1'b0, 32'h1000 + 32'(k));
      @(negedge clk);
      chk1($sformatf("zw%0d_req", k), bus_req_o, (k % 2 == 1));
      if (!if_stallreq_o) begin
        deliveries++;
        chk32($sformatf("zw%0d_idata", k), if_data_o, 32'h1000 + 32'(k));
      end
      nxt();
    end
    chk32("zw_deliveries", 32'(deliveries), 32'd5);

    // ---------------- async reset mid-transaction ----------------
    do_reset();
    if_addr_i = 32'h80;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 32'hCAFE0000);
    nxt();
    @(negedge clk);
    chk1("ar_req_before", bus_req_o, 1'b1);
    d_ce_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'hF;
    #2 rst = 1'b1;
    #1;
    chk1("ar_req", bus_req_o, 1'b0);
    chk1("ar_we", bus_we_o, 1'b0);
    chk32("ar_sel", 32'(bus_sel_o), 32'h0);
    chk32("ar_addr", bus_addr_o, 32'h0);
    chk32("ar_wdata", bus_wdata_o, 32'h0);
    chk1("ar_istall", if_stallreq_o, 1'b0);
    chk1("ar_dstall", d_stallreq_o, 1'b0);
    chk32("ar_idata", if_data_o, 32'h0);
    chk32("ar_drdata", d_rdata_o, 32'h0);
    nxt();
    rst = 1'b0; d_ce_i = 1'b0; d_we_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      if (bus_req_o && bus_addr_o == 32'h80) seen = 1'b1;
      nxt();
    end
    chk1("ar_refetch_seen", seen, 1'b1);

    // ---------------- randomized traffic vs model ----------------
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      d_ce_i      = ($urandom_range(0, 1) == 1);
      d_we_i      = ($urandom_range(0, 1) == 1);
      d_sel_i     = 4'($urandom());
      d_addr_i    = $urandom();
      d_wdata_i   = $urandom();
      if_ce_i     = ($urandom_range(0, 9) < 7);
      if_addr_i   = $urandom();
      stall_i     = 6'($urandom());
      flush_i     = ($urandom_range(0, 11) == 0);
      bus_ack_i   = ($urandom_range(0, 4) < 2);
      bus_rdata_i = $urandom();
      @(negedge clk);
      model_check();
      model_step();
      nxt();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one external memory bus with a req/ack handshake between the instruction-fetch port and the data-access port of the openmips core. It replaces the separate rom/ram paths. The block sits between the core's pc_reg/mem stages and the system bus. It raises per-port stall requests to ctrl while an access is outstanding, and it drains bus transactions that are orphaned by an exception flush.

## Interface
Parameters:
- ADDR_W, 32, bus/port address width
- DATA_W, 32, bus/port data width

Ports (the clock is `clk`; `rst` is asynchronous and active-high):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall_i  in  6  stall vector from ctrl; bit1 = IF/ID hold, bit4 = MEM/WB hold
- flush_i  in  1  exception flush from ctrl
- if_ce_i  in  1  fetch request (pc_reg ce)
- if_addr_i  in  ADDR_W  fetch address
- if_data_o  out  DATA_W  fetched instruction
- if_stallreq_o  out  1  fetch not yet complete
- d_ce_i  in  1  data request
- d_we_i  in  1  1 = write
- d_sel_i  in  4  byte enables
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_rdata_o  out  DATA_W  load data
- d_stallreq_o  out  1  data access not yet complete
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_sel_o  out  4  bus byte enables
- bus_addr_o  out  ADDR_W  bus address
- bus_wdata_o  out  DATA_W  bus write data
- bus_rdata_i  in  DATA_W  bus read data, valid with ack
- bus_ack_i  in  1  one-cycle completion strobe

## Operation
- FSM states: IDLE, BUS_D, BUS_I, DRAIN.
- IDLE: the data port wins over fetch.
  - If d_ce_i=1 and d_done=0: latch the data request into the bus registers and go to BUS_D.
  - Else if if_ce_i=1 and i_done=0: latch the fetch request (we=0, sel=4'hF) and go to BUS_I.
- BUS_D and BUS_I: bus_req_o and all bus fields are held stable until bus_ack_i=1.
  - On ack, set the port's done flag, capture bus_rdata_i into the port's hold register, and return to IDLE.
- Stall requests:
  - d_stallreq_o = d_ce_i & ~d_done & ~(state==BUS_D & bus_ack_i).
  - if_stallreq_o uses the same form with if_ce_i, i_done and BUS_I.
  - Both stall requests are forced to 1 in DRAIN whenever the corresponding ce is set.
- Read data:
  - d_rdata_o = d_done ? d_hold : bus_rdata_i.
  - if_data_o uses the same form with i_done and i_hold.
- Done flags:
  - d_done clears at an edge where stall_i[4]=0.
  - i_done clears at an edge where stall_i[1]=0.
  - Both flags clear on flush_i.
  - A flag that is set and cleared at the same edge ends up clear.
- Flush:
  - With flush_i=1 in BUS_D or BUS_I and no ack that cycle: go to DRAIN.
  - DRAIN keeps bus_req_o asserted and discards the returned data at ack, then returns to IDLE.
  - A flush that arrives together with ack returns directly to IDLE and drops the data.
- Writes are never reissued: d_done stays set while MEM is held by a stall.

## Timing
- Reset values:
  - state = IDLE.
  - bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o = 0.
  - Hold registers and done flags = 0.
  - Stall outputs = 0.
  - Data outputs = 0.
- All bus outputs are registered.
  - A request seen in cycle N drives bus_req_o in cycle N+1.
  - With ack in cycle N+1, the stall drops in N+1 and the pipeline advances at the end of N+1, so the minimum access is 2 cycles.
- bus_req_o deasserts in the cycle after ack unless a new request was latched at the ack edge. Back-to-back requests have one IDLE cycle between them.
- Data before fetch: on a simultaneous request, the fetch starts 1 cycle after the data ack.
- An ack seen in IDLE is ignored.
- Reset applied mid-transaction abandons the bus cycle immediately. Slaves must also be reset.

## Structure
- Shared defines: the state encodings, and `ChipEnable`/`WriteEnable` reused from the core's common defines.
- No sub-module; a single FSM with two hold registers.
- The openmips top instantiates the block; ctrl ORs the two stall requests into its existing id/ex request inputs.

## Test plan
- Fetch only, ack 3 cycles after req: if_stallreq_o=1 for 3 cycles, then if_data_o = bus_rdata_i (0x3C010001) with the stall dropped in the ack cycle.
- Simultaneous d_ce_i (load, 0x100) and if_ce_i (0x200): bus_addr_o=0x100 first, then 0x200. d_rdata_o stays at the held value until stall_i[4]=0.
- Store (sel=4'b0011, data 0xDEADBEEF) held by stall_i for 5 cycles after its ack: exactly one bus write is issued.
- flush_i mid-fetch before ack: FSM enters DRAIN; bus_req_o stays 1 until ack; returned data is discarded; the next fetch to new_pc 0x20 starts after drain.
- Zero-wait slave (ack one cycle after req): sustained fetch delivers one instruction every 2 cycles.
- rst pulsed while bus_req_o=1: all outputs go to 0 asynchronously, and after rst is released a pending if_ce_i reissues the fetch from IDLE.
